// File: rtl/jpeg_block_arbiter.sv
// jpeg_block_arbiter: round-robin arbiter that hands the shared DCT/quant datapath
// to one requester for a full block (start, BEATS coefficient beats, drain until dp_done).
module jpeg_block_arbiter #(
    parameter int N_REQ = 3,
    parameter int BEATS = 64,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CW-1:0]    beat_cnt,
    output logic             dp_start,
    input  logic             dp_done,
    output logic             blk_done,
    output logic             busy
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, START, BURST, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    last_q, last_d, gidx_q, gidx_d, win;
    logic [CW-1:0]    beat_q, beat_d;
    logic             found, accept, last_beat;
    int               idx;

    // Round-robin search upward from the requester after the last one served
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_q) + i) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign accept    = (state_q == BURST) && in_valid;
    assign last_beat = beat_q == CW'(BEATS - 1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                gnt_d = found ? N_REQ'(1) << win : '0;
                gidx_d = found ? win : gidx_q;
                state_d = found ? START : IDLE;
            end
            START: begin
                beat_d  = '0;
                state_d = BURST;
            end
            BURST: begin
                beat_d  = accept ? (last_beat ? '0 : beat_q + CW'(1)) : beat_q;
                state_d = (accept && last_beat) ? DRAIN : BURST;
            end
            DRAIN: begin
                last_d  = dp_done ? gidx_q : last_q;
                gnt_d   = dp_done ? '0 : gnt_q;
                state_d = dp_done ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
            gidx_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
            beat_q  <= beat_d;
        end
    end

    assign gnt      = gnt_q;
    assign beat_cnt = beat_q;
    assign in_ready = state_q == BURST;
    assign dp_start = state_q == START;
    // A reset landing on the dp_done cycle aborts the block silently
    assign blk_done = (state_q == DRAIN) && dp_done && !rst;
    assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_jpeg_block_arbiter.sv
// tb_jpeg_block_arbiter: scenario tasks with a queue of expected grants per block.
module tb_jpeg_block_arbiter;
    localparam int BEATS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic       in_valid = 1'b0;
    logic       dp_done = 1'b0;
    logic [2:0] gnt;
    logic       in_ready, dp_start, blk_done, busy;
    logic [5:0] beat_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int blk_cnt = 0;
    logic [2:0] exp_q[$];

    jpeg_block_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .in_valid(in_valid),
        .in_ready(in_ready), .beat_cnt(beat_cnt), .dp_start(dp_start),
        .dp_done(dp_done), .blk_done(blk_done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (blk_done === 1'b1) blk_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_block(input bit toggle, input int done_delay, input bit bogus,
                            input int drop_at, output int waited);
        logic [2:0] e;
        int acc, c, b0;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (gnt === 3'b000 && waited < 20);
        n_cmp++;
        if (gnt === 3'b000) begin
            n_err++;
            $display("FAIL grant_timeout: gnt=%b after %0d cycles, required a grant", gnt, waited);
            return;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (gnt !== e) begin
            n_err++;
            $display("FAIL grant: gnt=%b required %b", gnt, e);
        end
        n_cmp++;
        if (dp_start !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_outputs: dp_start=%b in_ready=%b busy=%b required 1 0 1",
                     dp_start, in_ready, busy);
        end
        b0 = blk_cnt;
        acc = 0;
        c = 0;
        tick();
        while (in_ready === 1'b1 && c < 400) begin
            n_cmp++;
            if (beat_cnt !== 6'(acc) || gnt !== e || dp_start !== 1'b0) begin
                n_err++;
                $display("FAIL burst: beat_cnt=%0d gnt=%b dp_start=%b required %0d %b 0",
                         beat_cnt, gnt, dp_start, acc, e);
            end
            in_valid = toggle ? (c % 2 == 0) : 1'b1;
            dp_done = bogus && (c == 5);
            c++;
            if (in_valid) acc++;
            if (acc == drop_at) req = 3'b000;
            tick();
        end
        in_valid = 1'b0;
        dp_done = 1'b0;
        n_cmp++;
        if (acc != BEATS) begin
            n_err++;
            $display("FAIL accepts: %0d beats accepted, required %0d", acc, BEATS);
        end
        if (!toggle) begin
            n_cmp++;
            if (c != BEATS) begin
                n_err++;
                $display("FAIL burst_len: %0d burst cycles, required %0d", c, BEATS);
            end
        end
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || beat_cnt !== 6'd0 || gnt !== e) begin
            n_err++;
            $display("FAIL drain_entry: busy=%b in_ready=%b beat_cnt=%0d gnt=%b required 1 0 0 %b",
                     busy, in_ready, beat_cnt, gnt, e);
        end
        for (int i = 0; i < done_delay; i++) begin
            n_cmp++;
            if (blk_done !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL drain_wait: blk_done=%b busy=%b required 0 1", blk_done, busy);
            end
            tick();
        end
        dp_done = 1'b1;
        #1;
        n_cmp++;
        if (blk_done !== 1'b1) begin
            n_err++;
            $display("FAIL blk_done: blk_done=%b required 1", blk_done);
        end
        tick();
        dp_done = 1'b0;
        n_cmp++;
        if (gnt !== 3'b000 || busy !== 1'b0 || in_ready !== 1'b0 || blk_cnt != b0 + 1) begin
            n_err++;
            $display("FAIL block_end: gnt=%b busy=%b in_ready=%b blocks=%0d required 000 0 0 %0d",
                     gnt, busy, in_ready, blk_cnt - b0, 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (gnt !== 3'b000 || in_ready !== 1'b0 || beat_cnt !== 6'd0 || dp_start !== 1'b0 ||
            blk_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: gnt=%b rdy=%b cnt=%0d start=%b done=%b busy=%b required all 0",
                     gnt, in_ready, beat_cnt, dp_start, blk_done, busy);
        end
        rst = 1'b0;
        dp_done = 1'b1;
        tick();
        dp_done = 1'b0;
        tick();
        n_cmp++;
        if (gnt !== 3'b000 || busy !== 1'b0 || blk_cnt != 0) begin
            n_err++;
            $display("FAIL idle_no_req: gnt=%b busy=%b blocks=%0d required 000 0 0", gnt, busy, blk_cnt);
        end
    endtask

    task automatic test_fairness();
        int w;
        req = 3'b111;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b001);
        for (int k = 0; k < 4; k++) begin
            do_block(1'b0, 0, 1'b0, -1, w);
            n_cmp++;
            if (w != 1) begin
                n_err++;
                $display("FAIL back_to_back: grant after %0d cycles, required 1", w);
            end
        end
    endtask

    task automatic test_single();
        int w;
        req = 3'b010;
        exp_q.push_back(3'b010);
        do_block(1'b0, 1, 1'b0, -1, w);
    endtask

    task automatic test_toggle();
        int w;
        req = 3'b001;
        exp_q.push_back(3'b001);
        do_block(1'b1, 0, 1'b0, -1, w);
    endtask

    task automatic test_drop();
        int w;
        req = 3'b100;
        exp_q.push_back(3'b100);
        do_block(1'b0, 0, 1'b0, 10, w);
        tick();
        n_cmp++;
        if (gnt !== 3'b000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL drop_idle: gnt=%b busy=%b required 000 0", gnt, busy);
        end
    endtask

    task automatic test_bogus_done();
        int w;
        req = 3'b010;
        exp_q.push_back(3'b010);
        do_block(1'b0, 3, 1'b1, -1, w);
    endtask

    task automatic test_reset_mid();
        int w, b0;
        logic [2:0] e;
        req = 3'b100;
        exp_q.push_back(3'b100);
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (gnt !== e) begin
            n_err++;
            $display("FAIL reset_mid_grant: gnt=%b required %b", gnt, e);
        end
        tick();
        in_valid = 1'b1;
        repeat (30) tick();
        n_cmp++;
        if (beat_cnt !== 6'd30) begin
            n_err++;
            $display("FAIL reset_mid_beat: beat_cnt=%0d required 30", beat_cnt);
        end
        b0 = blk_cnt;
        rst = 1'b1;
        dp_done = 1'b1;
        tick();
        rst = 1'b0;
        dp_done = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (gnt !== 3'b000 || in_ready !== 1'b0 || beat_cnt !== 6'd0 || dp_start !== 1'b0 ||
            blk_done !== 1'b0 || busy !== 1'b0 || blk_cnt != b0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: gnt=%b rdy=%b cnt=%0d start=%b busy=%b blocks=%0d required all 0",
                     gnt, in_ready, beat_cnt, dp_start, busy, blk_cnt - b0);
        end
        req = 3'b111;
        exp_q.push_back(3'b001);
        do_block(1'b0, 0, 1'b0, -1, w);
        req = 3'b000;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_toggle();
        test_drop();
        test_bogus_done();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d expected grants left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
